cp0_random: RTL and testbench
=============================

# cp0_random

CP0 Random register (CP0 reg 1) for the pipelined MIPS core's TLB. It sits directly downstream of the CP0 Wired register and consumes its output as the lower bound of a free-running down-counter. It supplies the replacement index for TLBWR through a one-cycle request/acknowledge handshake. It also provides the read value for MFC0 of Random.

## Interface
- `TLB_ENTRIES`, default 16: number of TLB entries; Random ranges over `[lb, TLB_ENTRIES-1]`.
- `IDX_W`, default 4: index width, equal to clog2(`TLB_ENTRIES`).

- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `stall`  input  1  pipeline hold; freezes the counter.
- `wired_we`  input  1  the same strobe that writes CP0 Wired (MTC0 to reg 6).
- `wired`  input  32  Q output of CP0 Wired; only bits `[IDX_W-1:0]` are used.
- `tlbwr_req`  input  1  TLBWR request from EX; held high until acknowledged.
- `random`  output  32  Random read value, zero-extended counter.
- `tlbwr_ack`  output  1  one-cycle acknowledge.
- `tlbwr_idx`  output  IDX_W  captured replacement index, valid while `tlbwr_ack`=1.
- `wired_bad`  output  1  combinational flag: `wired[IDX_W-1:0]` >= `TLB_ENTRIES`.

## Operation
- Internal counter `rnd[IDX_W-1:0]`.
- Lower bound `lb`:
  - `lb` = `wired[IDX_W-1:0]` when that value is less than `TLB_ENTRIES`.
  - Otherwise `lb` = `TLB_ENTRIES-1`, and `wired_bad`=1.
- Counter update, in priority order:
  1. `wired_we`=1: `rnd` <= `TLB_ENTRIES-1`. This applies regardless of `stall` or handshake state.
  2. `stall`=1 and FSM in IDLE: `rnd` holds.
  3. Otherwise, if `rnd` <= `lb`, then `rnd` <= `TLB_ENTRIES-1` (wrap); else `rnd` <= `rnd-1`.
- Because of the rule in (2), the counter always advances during GRANT, even when stalled. This guarantees that back-to-back TLBWRs do not see the same index.
- The comparison uses the `wired` value present in the cycle. On a `wired_we` cycle the new Wired value appears one cycle later, together with the reloaded `rnd`.
- `random` = {zeros, `rnd`}, registered; it is never written by software.
- Handshake FSM:
  - IDLE:
    - `tlbwr_req`=1 and `wired_we`=0: capture `tlbwr_idx` <= `rnd` and go to GRANT.
    - `tlbwr_req`=1 and `wired_we`=1: the request is deferred. It stays in IDLE and is captured next cycle, when `rnd`=`TLB_ENTRIES-1`.
    - `stall` does not block capture.
  - GRANT: `tlbwr_ack`=1 for exactly one cycle, then return to IDLE unconditionally.
    - `tlbwr_req` seen while in GRANT is ignored. The requester drops `req` on `ack`.
    - A `req` still high in the cycle after GRANT starts a new transaction.
- `tlbwr_idx` holds its last captured value outside GRANT.

## Timing
- Reset values (asynchronous, while `rst`=0):
  - `rnd`=`TLB_ENTRIES-1`, so `random`=`TLB_ENTRIES-1`.
  - FSM=IDLE, `tlbwr_ack`=0, `tlbwr_idx`=0.
- `wired_bad` follows `wired` combinationally; it is 0 after reset because Wired resets to 0.
- Counter latency: one edge per step; a reload caused by `wired_we` is visible on `random` one cycle later.
- TLBWR latency: `req` sampled high at edge N, giving `ack`=1 and `idx`=`rnd` value before edge N, during cycle N+1.
- Reset asserted mid-GRANT: `ack` drops immediately and the FSM returns to IDLE.
- Wired = `TLB_ENTRIES-1`: the counter is stuck at `TLB_ENTRIES-1`; this is legal.
- Wired = 0: full cycle through `TLB_ENTRIES-1` down to 0, then wrap.
- Counter never leaves the range `[lb, TLB_ENTRIES-1]` except transiently, when Wired increases above the current `rnd`. In that case the next step wraps to `TLB_ENTRIES-1`.

## Test plan
- Reset, then release with `wired`=0, `stall`=0 -> `random` = 15, 14, …, 0, 15 on successive cycles; `ack`=0 throughout.
- Pulse `wired_we` with `wired` changing to 4 while `rnd`=9 -> `random`=15 next cycle, then counts 14 down to 4, then 15; value 3 never appears.
- `stall`=1 for 5 cycles at `rnd`=7 -> `random` stays 7; it resumes at 6 after `stall` drops.
- `tlbwr_req` rises while `rnd`=9 and `stall`=1 -> one cycle later `ack`=1 and `idx`=9, and the counter advances to 8 despite the stall; `ack`=0 the cycle after.
- `tlbwr_req` and `wired_we` asserted together at `rnd`=5 -> no `ack` next cycle; `ack`=1 with `idx`=15 one cycle after that.
- `wired`=15 with `TLB_ENTRIES`=16 -> `random` is constant 15. Instance with `TLB_ENTRIES`=12 and `wired`=13 -> `wired_bad`=1 and `random` is constant 11. Drop `rst` during `ack` -> `ack`=0 immediately and `random`=15.

Source files
------------

// File: rtl/cp0_random.sv
// CP0 Random register (reg 1).
// Down-counter over [lb, TLB_ENTRIES-1] that supplies the TLBWR replacement
// index through a one-cycle req/ack handshake and the MFC0 read value.
// The lower bound lb comes from CP0 Wired. A Wired value that is out of
// range is clamped to the top entry and flagged on wired_bad.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for tlbwr_req; a stall freezes the counter
// GRANT | tlbwr_ack high for one cycle; the counter always advances
module cp0_random #(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             wired_we,
  input  logic [31:0]      wired,
  input  logic             tlbwr_req,
  output logic [31:0]      random,
  output logic             tlbwr_ack,
  output logic [IDX_W-1:0] tlbwr_idx,
  output logic             wired_bad
);

  localparam logic [IDX_W-1:0] TOP = IDX_W'(TLB_ENTRIES - 1);
  // One extra bit so the entry count itself is representable, e.g. 16 in 4-bit indices.
  localparam logic [IDX_W:0]   ENT = (IDX_W + 1)'(TLB_ENTRIES);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state;
  logic [IDX_W-1:0] rnd;
  logic [IDX_W-1:0] wired_idx;
  logic [IDX_W-1:0] lb;
  logic             unused_wired;

  assign wired_idx    = wired[IDX_W-1:0];
  assign unused_wired = |wired[31:IDX_W];

  // Clamp an out-of-range Wired to the top entry so the counter stays legal.
  assign wired_bad = ({1'b0, wired_idx} >= ENT);
  assign lb        = wired_bad ? TOP : wired_idx;

  assign random = {{(32 - IDX_W){1'b0}}, rnd};

  // Counter: a Wired write reloads it, a stall holds it only in IDLE, otherwise it steps down and wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rnd <= TOP;
    end else if (wired_we) begin
      rnd <= TOP;
    end else if (stall && (state == IDLE)) begin
      rnd <= rnd;
    end else if (rnd <= lb) begin
      rnd <= TOP;
    end else begin
      rnd <= rnd - 1'b1;
    end
  end

  // Handshake FSM. A request that coincides with a Wired write is left
  // pending so that it picks up the reloaded top index on the next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tlbwr_ack <= 1'b0;
      tlbwr_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tlbwr_req && !wired_we) begin
            state     <= GRANT;
            tlbwr_ack <= 1'b1;
            tlbwr_idx <= rnd;
          end else begin
            tlbwr_ack <= 1'b0;
          end
        end
        GRANT: begin
          state     <= IDLE;
          tlbwr_ack <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          tlbwr_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_random.sv
// Bench for cp0_random: a vector table drives a 16-entry instance through a scoreboard queue.
// Hand-written sequences cover reset during GRANT and a 12-entry instance with out-of-range Wired.
module tb_cp0_random;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, wired_we = 1'b0, tlbwr_req = 1'b0;
  logic [31:0] wired = 32'd0;
  logic [31:0] random;
  logic        tlbwr_ack, wired_bad;
  logic [3:0]  tlbwr_idx;

  logic        stall12 = 1'b0, wired_we12 = 1'b0, req12 = 1'b0;
  logic [31:0] wired12 = 32'd13;
  logic [31:0] random12;
  logic        ack12, wired_bad12;
  logic [3:0]  idx12;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  cp0_random #(.TLB_ENTRIES(16), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .wired_we(wired_we), .wired(wired),
    .tlbwr_req(tlbwr_req), .random(random), .tlbwr_ack(tlbwr_ack),
    .tlbwr_idx(tlbwr_idx), .wired_bad(wired_bad)
  );

  cp0_random #(.TLB_ENTRIES(12), .IDX_W(4)) dut12 (
    .clk(clk), .rst(rst), .stall(stall12), .wired_we(wired_we12), .wired(wired12),
    .tlbwr_req(req12), .random(random12), .tlbwr_ack(ack12),
    .tlbwr_idx(idx12), .wired_bad(wired_bad12)
  );

  typedef struct {
    logic        stall;
    logic        we;
    logic [31:0] wired;
    logic        req;
    logic [31:0] e_rand;
    logic        e_ack;
    logic [3:0]  e_idx;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic add(input logic s, input logic we, input logic [31:0] w, input logic req,
                     input logic [31:0] er, input logic ea, input logic [3:0] ei);
    vec_t v;
    v.stall = s; v.we = we; v.wired = w; v.req = req;
    v.e_rand = er; v.e_ack = ea; v.e_idx = ei;
    tbl.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    // Full cycle with Wired = 0: 14 down to 0, then wrap to 15.
    for (int k = 1; k <= 16; k++) add(0, 0, 0, 0, (k == 16) ? 32'd15 : 32'(15 - k), 0, 0);
    for (int v = 14; v >= 9; v--) add(0, 0, 0, 0, 32'(v), 0, 0);
    // Wired write at rnd=9. The new Wired value 4 appears one cycle later, with the reload.
    add(0, 1, 0, 0, 15, 0, 0);
    for (int v = 14; v >= 4; v--) add(0, 0, 4, 0, 32'(v), 0, 0);
    add(0, 0, 4, 0, 15, 0, 0);
    for (int v = 14; v >= 7; v--) add(0, 0, 4, 0, 32'(v), 0, 0);
    // Stall for 5 cycles at 7, then resume.
    repeat (5) add(1, 0, 4, 0, 7, 0, 0);
    add(0, 0, 4, 0, 6, 0, 0);
    add(0, 0, 4, 0, 5, 0, 0);
    add(0, 0, 4, 0, 4, 0, 0);
    add(0, 0, 4, 0, 15, 0, 0);
    for (int v = 14; v >= 9; v--) add(0, 0, 4, 0, 32'(v), 0, 0);
    // TLBWR under stall at rnd=9: the capture cycle holds, and GRANT advances despite the stall.
    add(1, 0, 4, 1, 9, 1, 9);
    add(1, 0, 4, 0, 8, 0, 9);
    add(0, 0, 4, 0, 7, 0, 9);
    add(0, 0, 4, 0, 6, 0, 9);
    add(0, 0, 4, 0, 5, 0, 9);
    // Request together with a Wired write at rnd=5: the request is deferred and then gets index 15.
    add(0, 1, 4, 1, 15, 0, 9);
    add(0, 0, 2, 1, 14, 1, 15);
    add(0, 0, 2, 0, 13, 0, 15);
    // req held high: ignored in GRANT, then starts a new transaction.
    add(0, 0, 2, 1, 12, 1, 13);
    add(0, 0, 2, 1, 11, 0, 13);
    add(0, 0, 2, 1, 10, 1, 11);
    add(0, 0, 2, 0, 9, 0, 11);
    // Wired = 15: the counter is stuck at 15.
    add(0, 1, 2, 0, 15, 0, 11);
    repeat (3) add(0, 0, 15, 0, 15, 0, 11);
    add(0, 0, 15, 1, 15, 1, 15);
    add(0, 0, 15, 0, 15, 0, 15);
    // Back to Wired = 0, then a request whose GRANT cycle is hit by reset below.
    add(0, 1, 15, 0, 15, 0, 15);
    add(0, 0, 0, 0, 14, 0, 15);
    add(0, 0, 0, 1, 13, 1, 14);

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_random", random, 15);
    chk("reset_ack", {31'd0, tlbwr_ack}, 0);
    chk("reset_idx", {28'd0, tlbwr_idx}, 0);
    chk("reset_wired_bad", {31'd0, wired_bad}, 0);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      stall = tbl[i].stall; wired_we = tbl[i].we; wired = tbl[i].wired; tlbwr_req = tbl[i].req;
      sb.push_back(tbl[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      chk($sformatf("random[%0d]", i), random, e.e_rand);
      chk($sformatf("ack[%0d]", i), {31'd0, tlbwr_ack}, {31'd0, e.e_ack});
      chk($sformatf("idx[%0d]", i), {28'd0, tlbwr_idx}, {28'd0, e.e_idx});
    end
    tlbwr_req = 1'b0;

    // Reset in the middle of GRANT: ack drops at once, without waiting for a clock edge.
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_ack", {31'd0, tlbwr_ack}, 0);
    chk("rst_mid_random", random, 15);
    chk("rst_mid_idx", {28'd0, tlbwr_idx}, 0);

    // 12-entry instance with Wired = 13: flagged, and the counter stays pinned at 11.
    @(posedge clk); #1;
    wired12 = 32'd13;
    rst = 1'b1;
    #1;
    chk("w12_bad", {31'd0, wired_bad12}, 1);
    chk("w12_reset_random", random12, 11);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("w12_stuck[%0d]", k), random12, 11);
    end
    wired12 = 32'd0;
    #1;
    chk("w12_bad_clear", {31'd0, wired_bad12}, 0);
    @(posedge clk); #1;
    chk("w12_count0", random12, 10);
    @(posedge clk); #1;
    chk("w12_count1", random12, 9);
    chk("w12_ack", {31'd0, ack12}, 0);
    chk("w12_idx", {28'd0, idx12}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
